button_dir_ctrl: RTL
====================

BUTTON_DIR_CTRL -- requirements
Module: button_dir_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, SHALL set the number of consecutive clk cycles a synchronized button level must hold before it is accepted (10 ms at 25 MHz); legal range 2..2^20.
REQ-002 clk  input  1  single system clock (25 MHz processor clock); all state SHALL be clocked on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 BTNU  input  1  raw up button, asynchronous to clk.
REQ-005 BTNR  input  1  raw right button, asynchronous to clk.
REQ-006 BTND  input  1  raw down button, asynchronous to clk.
REQ-007 BTNL  input  1  raw left button, asynchronous to clk.
REQ-008 rd_ack  input  1  one-cycle pulse asserted when the processor reads data address 0; it consumes the pending direction.
REQ-009 button_reg  output  3  pending direction code: 0 = none, 1 = up, 2 = right, 3 = down, 4 = left; codes 5..7 SHALL never appear.
REQ-010 dir_valid  output  1  high exactly when button_reg != 0.

Function
REQ-011 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each button SHALL own an independent debounce counter and stable-level flop.
  - Counter clears whenever the synchronized level equals the stable level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level is updated and the counter clears.
REQ-013 A press event SHALL be a 0->1 transition of a stable level; 1->0 transitions and held levels SHALL generate no event.
REQ-014 When several press events occur in the same cycle, exactly one SHALL be taken, with priority up > right > down > left.
REQ-015 An accepted press SHALL load its code into button_reg on the next rising edge; a newer accepted press overwrites an unread one (latest wins, no queue).
REQ-016 rd_ack with no accepted press in the same cycle SHALL clear button_reg to 0 on the next edge.
REQ-017 rd_ack coincident with an accepted press SHALL leave the new press code in button_reg; the new press is not consumed.
REQ-018 rd_ack while button_reg == 0 SHALL have no effect.
REQ-019 Latency from a clean raw edge to button_reg update SHALL be exactly 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
REQ-020 A raw glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no event and SHALL reset that button's counter progress.
REQ-021 Debounce counters SHALL saturate-free wrap only through the clear in REQ-012; no counter SHALL exceed DEBOUNCE_CYCLES-1.

Reset
REQ-022 Asserting reset low SHALL immediately and asynchronously clear the following:
  - all synchronizer flops, stable levels and counters to 0;
  - button_reg to 0 and dir_valid to 0;
  - the last-direction register (Configuration) to 0.
REQ-023 A button held through reset release SHALL be accepted as a press after the REQ-019 latency, measured from release.
REQ-024 Reset asserted mid-debounce SHALL discard all in-progress counts; no event SHALL be emitted for that press.

Configuration
REQ-025 Macro BTN_REVERSE_BLOCK_EN, when defined, SHALL add a 3-bit last-direction register.
  - The register is updated with every accepted code.
  - A press whose code is the opposite of the last direction (1<->3, 2<->4) SHALL be dropped: no button_reg update and no last-direction update.
  - A dropped press SHALL not mask a lower-priority simultaneous press; the next-priority non-opposite press is taken.
  - With last direction 0, no press is dropped.
REQ-026 Without BTN_REVERSE_BLOCK_EN, the register SHALL not exist and all presses SHALL be accepted per REQ-014/015.

Verification (DEBOUNCE_CYCLES = 4)
REQ-027 Clean press: BTNR held high from cycle 10 -> button_reg = 2 and dir_valid = 1 at cycle 17; rd_ack at cycle 20 -> button_reg = 0 at cycle 21.
REQ-028 Glitch rejection: BTNU high for 3 cycles then low -> button_reg stays 0 for 50 cycles.
REQ-029 Simultaneous press: BTNU and BTNL rise together -> button_reg = 1; no later event for left while both are held.
REQ-030 Collision: rd_ack in the same cycle a BTND press is accepted while button_reg = 4 -> button_reg = 3 next cycle, then cleared by a later rd_ack.
REQ-031 Reverse block (macro defined): press up (read, cleared), then press down -> button_reg stays 0; then press left -> button_reg = 4. With the macro undefined, the same sequence gives down -> button_reg = 3.
REQ-032 Async reset: drive reset low mid-count while button_reg = 2 -> button_reg = 0 in the same cycle without a clk edge; after release with BTNL held -> button_reg = 4 after 7 cycles.

Source files
------------

// File: rtl/button_dir_ctrl_if.sv
// Processor-side bus of the button direction controller:
// the read acknowledge from the CPU plus the pending direction outputs.
interface button_dir_ctrl_if;
  logic       rd_ack;
  logic [2:0] button_reg;
  logic       dir_valid;

  modport master (output rd_ack, input button_reg, input dir_valid);
  modport slave  (input rd_ack, output button_reg, output dir_valid);
endinterface

// File: rtl/button_dir_ctrl.sv
// Four-button direction controller: each raw button is synchronized,
// debounced, and rising edges of the debounced level become press events.
// The highest-priority press (up > right > down > left) is latched as a
// direction code until the processor acknowledges the read.
// Optional feature macro: BTN_REVERSE_BLOCK_EN drops presses that reverse
// the last accepted direction.
module button_dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               BTNU,
  input  logic               BTNR,
  input  logic               BTND,
  input  logic               BTNL,
  button_dir_ctrl_if.slave   bus
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Bit index doubles as priority order: 0 = up ... 3 = left.
  logic [3:0] w_raw;
  logic [3:0] w_press;
  logic [3:0] w_take;
  logic [2:0] w_code;

  logic [2:0] r_button;
  logic       r_valid;

  assign w_raw = {BTNL, BTND, BTNR, BTNU};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic          r_sync1;
      logic          r_sync2;
      logic          r_stable;
      logic          r_stable_d;
      logic [CW-1:0] r_cnt;

      // Synchronize, debounce and remember the previous stable level.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_sync1    <= 1'b0;
          r_sync2    <= 1'b0;
          r_stable   <= 1'b0;
          r_stable_d <= 1'b0;
          r_cnt      <= '0;
        end else begin
          r_sync1    <= w_raw[gi];
          r_sync2    <= r_sync1;
          r_stable_d <= r_stable;
          if (r_sync2 == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      // A press is a 0->1 step of the debounced level.
      assign w_press[gi] = r_stable & ~r_stable_d;
    end
  endgenerate

`ifdef BTN_REVERSE_BLOCK_EN
  logic [2:0] r_last;
  logic [3:0] w_block;

  // Mask the single button whose code reverses the last direction.
  always_comb begin
    w_block = 4'b0000;
    case (r_last)
      3'd1:    w_block[2] = 1'b1;
      3'd2:    w_block[3] = 1'b1;
      3'd3:    w_block[0] = 1'b1;
      3'd4:    w_block[1] = 1'b1;
      default: w_block = 4'b0000;
    endcase
  end

  assign w_take = w_press & ~w_block;

  // Track the most recent accepted direction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= 3'd0;
    end else if (w_code != 3'd0) begin
      r_last <= w_code;
    end
  end
`else
  assign w_take = w_press;
`endif

  // Fixed-priority pick among surviving presses.
  always_comb begin
    w_code = 3'd0;
    if (w_take[0])      w_code = 3'd1;
    else if (w_take[1]) w_code = 3'd2;
    else if (w_take[2]) w_code = 3'd3;
    else if (w_take[3]) w_code = 3'd4;
  end

  // Latch a new press (wins over rd_ack), otherwise clear on read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_button <= 3'd0;
      r_valid  <= 1'b0;
    end else if (w_code != 3'd0) begin
      r_button <= w_code;
      r_valid  <= 1'b1;
    end else if (bus.rd_ack) begin
      r_button <= 3'd0;
      r_valid  <= 1'b0;
    end
  end

  assign bus.button_reg = r_button;
  assign bus.dir_valid  = r_valid;

endmodule
